// File: rtl/dram_cache_pkg.sv
// Shared widths, tag bit positions and FSM states
// for the DRAM cache AXI master.
package dram_cache_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 512;
  localparam int ID_W     = 16;
  localparam int TAG_S    = 64;
  localparam int INDEX_W  = 26;
  localparam int OFFSET_W = 6;
  localparam int BLANK_W  = 30;

  localparam int TAG_VALID = 63;
  localparam int TAG_DIRTY = 62;
  localparam int TAG_HI    = 61;
  localparam int TAG_LO    = 30;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW,
    W,
    B,
    RESP
  } state_t;

endpackage

// File: rtl/dram_cache_tag_cmp.sv
// Tag check: a line hits when its tag is valid and
// its stored tag field matches the upper address bits.
module dram_cache_tag_cmp
  import dram_cache_pkg::*;
(
  input  logic [TAG_S-1:0]  tag,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              dirty
);

  logic unused_bits;

  // Pure combinational compare of the stored tag field
  always_comb begin
    hit = tag[TAG_VALID] &&
          (tag[TAG_HI:TAG_LO] == addr[ADDR_W-1:32]);
    dirty = tag[TAG_DIRTY];
  end

  // Index/offset bits and blank tag bits play no part in the compare
  assign unused_bits = ^{addr[31:0], tag[BLANK_W-1:0]};

endmodule

// File: rtl/dram_cache_axi_master.sv
// Single-outstanding AXI master that reads or fills
// one DRAM cache line (tag + data) per request.
module dram_cache_axi_master
  import dram_cache_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 16'd1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [DATA_W-1:0]       req_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    resp_hit_o,
  output logic                    resp_dirty_o,
  output logic                    resp_err_o,
  output logic [DATA_W-1:0]       resp_rdata_o,
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_W-1:0]         rid_i,
  input  logic [TAG_S+DATA_W-1:0] rdata_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [ID_W-1:0]         awid_o,
  output logic [ADDR_W-1:0]       awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_W-1:0]         wid_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hit_w;
  logic              dirty_w;

  dram_cache_tag_cmp u_tag_cmp (
    .tag   (rdata_i[TAG_S+DATA_W-1:DATA_W]),
    .addr  (addr_q),
    .hit   (hit_w),
    .dirty (dirty_w)
  );

  // Address and data leave straight from the capture registers
  assign arid_o   = AXI_ID;
  assign awid_o   = AXI_ID;
  assign wid_o    = AXI_ID;
  assign araddr_o = addr_q;
  assign awaddr_o = addr_q;
  assign wdata_o  = wdata_q;

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_o  <= 1'b1;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      awvalid_o    <= 1'b0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_dirty_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            req_ready_o <= 1'b0;
            if (req_write_i) begin
              awvalid_o <= 1'b1;
              state     <= AW;
            end else begin
              arvalid_o <= 1'b1;
              state     <= AR;
            end
          end
        end
        AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (rvalid_i) begin
            rready_o     <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_hit_o   <= hit_w;
            resp_dirty_o <= dirty_w;
            resp_err_o   <= (rid_i != AXI_ID);
            resp_rdata_o <= rdata_i[DATA_W-1:0];
            state        <= RESP;
          end
        end
        AW: begin
          if (awready_i) begin
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b1;
            state     <= W;
          end
        end
        W: begin
          if (wready_i) begin
            wvalid_o <= 1'b0;
            bready_o <= 1'b1;
            state    <= B;
          end
        end
        B: begin
          if (bvalid_i) begin
            bready_o     <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_hit_o   <= 1'b0;
            resp_dirty_o <= 1'b0;
            resp_err_o   <= (bid_i != AXI_ID);
            resp_rdata_o <= '0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cache_axi_master.sv
// Directed bench: AXI slave memory model, transaction-level
// reference model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_dram_cache_axi_master;

  localparam logic [15:0] ID = 16'd1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_write_i = 1'b0;
  logic [63:0]  req_addr_i = '0;
  logic [511:0] req_wdata_i = '0;
  logic         resp_valid_o;
  logic         resp_ready_i = 1'b0;
  logic         resp_hit_o;
  logic         resp_dirty_o;
  logic         resp_err_o;
  logic [511:0] resp_rdata_o;
  logic [15:0]  arid_o;
  logic [63:0]  araddr_o;
  logic         arvalid_o;
  logic         arready_i = 1'b0;
  logic [15:0]  rid_i = '0;
  logic [575:0] rdata_i = '0;
  logic         rvalid_i = 1'b0;
  logic         rready_o;
  logic [15:0]  awid_o;
  logic [63:0]  awaddr_o;
  logic         awvalid_o;
  logic         awready_i = 1'b0;
  logic [15:0]  wid_o;
  logic [511:0] wdata_o;
  logic         wvalid_o;
  logic         wready_i = 1'b0;
  logic [15:0]  bid_i = '0;
  logic         bvalid_i = 1'b0;
  logic         bready_o;

  always #5 clk = ~clk;

  dram_cache_axi_master #(.AXI_ID(ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_dirty_o(resp_dirty_o),
    .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .arid_o(arid_o), .araddr_o(araddr_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input logic [639:0] act,
                     input logic [639:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_chk++;
    $display("FAIL %s: got no handshake want one", name);
  endtask

  // Slave-side line store, indexed by addr[31:6]
  logic [575:0] mem [logic [25:0]];

  function automatic logic [63:0] mk_tag(bit v, bit d,
                                         logic [31:0] t);
    mk_tag = {v, d, t, 30'b0};
  endfunction

  function automatic logic [575:0] line_of(logic [63:0] a);
    if (mem.exists(a[31:6])) line_of = mem[a[31:6]];
    else line_of = '0;
  endfunction

  // Reference model state (transaction level)
  bit           mv, m_rst, m_busy, m_wr;
  bit           m_ar, m_r, m_aw, m_w, m_b, m_pend;
  logic [63:0]  m_addr;
  logic [511:0] m_wdata;
  logic         e_hit, e_dirty, e_err;
  logic [511:0] e_rdata;
  logic [63:0]  e_tag;
  int           resp_cnt = 0;
  logic         l_hit, l_dirty, l_err;
  logic [511:0] l_rdata;

  // Compare DUT against the model, then advance the model
  always @(negedge clk) begin
    if (mv && m_rst) begin
      chk("rst_ctl",
          {req_ready_o, arvalid_o, rready_o, awvalid_o,
           wvalid_o, bready_o, resp_valid_o}, 7'b1000000);
      chk("rst_resp",
          {resp_hit_o, resp_dirty_o, resp_err_o, resp_rdata_o},
          '0);
    end else if (mv) begin
      chk("req_ready", req_ready_o, !m_busy);
      chk("arvalid", arvalid_o, m_busy && !m_wr && !m_ar);
      chk("rready", rready_o, m_busy && !m_wr && m_ar && !m_r);
      chk("awvalid", awvalid_o, m_busy && m_wr && !m_aw);
      chk("wvalid", wvalid_o, m_busy && m_wr && m_aw && !m_w);
      chk("bready", bready_o, m_busy && m_wr && m_w && !m_b);
      chk("resp_valid", resp_valid_o, m_pend);
      chk("ids", {arid_o, awid_o, wid_o}, {ID, ID, ID});
      if (arvalid_o) chk("araddr", araddr_o, m_addr);
      if (awvalid_o) chk("awaddr", awaddr_o, m_addr);
      if (wvalid_o) chk("wdata", wdata_o, m_wdata);
      if (resp_valid_o && m_pend)
        chk("resp",
            {resp_hit_o, resp_dirty_o, resp_err_o, resp_rdata_o},
            {e_hit, e_dirty, e_err, e_rdata});
    end
    if (!rst_n) begin
      mv = 1; m_rst = 1; m_busy = 0; m_pend = 0;
      {m_ar, m_r, m_aw, m_w, m_b} = '0;
    end else if (mv) begin
      m_rst = 0;
      if (!m_busy) begin
        if (req_valid_i) begin
          m_busy = 1; m_wr = req_write_i;
          m_addr = req_addr_i; m_wdata = req_wdata_i;
          {m_ar, m_r, m_aw, m_w, m_b} = '0;
        end
      end else begin
        if (arvalid_o && arready_i) m_ar = 1;
        if (rready_o && rvalid_i) begin
          m_r = 1; m_pend = 1;
          e_tag = rdata_i[575:512];
          e_hit = e_tag[63] && (e_tag[61:30] == m_addr[63:32]);
          e_dirty = e_tag[62];
          e_err = (rid_i != ID);
          e_rdata = rdata_i[511:0];
        end
        if (awvalid_o && awready_i) m_aw = 1;
        if (wvalid_o && wready_i) m_w = 1;
        if (bready_o && bvalid_i) begin
          m_b = 1; m_pend = 1;
          e_hit = 0; e_dirty = 0; e_rdata = '0;
          e_err = (bid_i != ID);
        end
        if (resp_valid_o && resp_ready_i) begin
          m_pend = 0; m_busy = 0; resp_cnt++;
          l_hit = resp_hit_o; l_dirty = resp_dirty_o;
          l_err = resp_err_o; l_rdata = resp_rdata_o;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with slave and response-side pacing
  task automatic txn(input bit wr, input logic [63:0] a,
                     input logic [511:0] d, input int ar_dly,
                     input int hold, input logic [15:0] id_ret,
                     input bit noise, input bit rst_w);
    int t;
    req_valid_i = 1; req_write_i = wr;
    req_addr_i = a; req_wdata_i = d;
    t = 0;
    while (!req_ready_o && t < 50) begin step(); t++; end
    if (!req_ready_o) tmo("accept");
    step();
    req_valid_i = noise;
    if (noise) begin
      req_write_i = ~wr;
      req_addr_i = 64'hDEAD_BEEF_0000_0FC0;
      req_wdata_i = {16{32'h1234_5678}};
    end
    if (!wr) begin
      t = 0;
      while (!arvalid_o && t < 50) begin step(); t++; end
      if (!arvalid_o) tmo("ar");
      repeat (ar_dly) step();
      arready_i = 1; step(); arready_i = 0;
      rvalid_i = 1; rid_i = id_ret; rdata_i = line_of(a);
      t = 0;
      while (!rready_o && t < 50) begin step(); t++; end
      if (!rready_o) tmo("r");
      step(); rvalid_i = 0;
    end else begin
      t = 0;
      while (!awvalid_o && t < 50) begin step(); t++; end
      if (!awvalid_o) tmo("aw");
      awready_i = 1; step(); awready_i = 0;
      t = 0;
      while (!wvalid_o && t < 50) begin step(); t++; end
      if (!wvalid_o) tmo("w");
      if (rst_w) begin
        repeat (2) step();
        req_valid_i = 0;
        rst_n = 0; step(); rst_n = 1;
        chk("rst_w_wvalid", wvalid_o, 1'b0);
        chk("rst_w_ready", req_ready_o, 1'b1);
        return;
      end
      wready_i = 1; step(); wready_i = 0;
      mem[a[31:6]] = {mk_tag(1, 0, a[63:32]), d};
      bvalid_i = 1; bid_i = id_ret;
      t = 0;
      while (!bready_o && t < 50) begin step(); t++; end
      if (!bready_o) tmo("b");
      step(); bvalid_i = 0;
    end
    t = 0;
    while (!resp_valid_o && t < 50) begin step(); t++; end
    if (!resp_valid_o) tmo("resp");
    repeat (hold) step();
    req_valid_i = 0;
    resp_ready_i = 1; step(); resp_ready_i = 0;
    step();
  endtask

  logic [511:0] pat_a5, pat_5a, pat_3c;
  logic [63:0]  a1, a2, a3, a4;
  int           c0;

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_5a = {64{8'h5A}};
    pat_3c = {64{8'h3C}};
    a1 = 64'h0000_0001_0000_0040;
    a2 = 64'h0000_0002_0000_0040;
    a3 = 64'h0000_0003_0000_0080;
    a4 = 64'h0000_0004_0000_00C0;
    mem[a3[31:6]] = {mk_tag(1, 1, 32'h3), pat_5a};
    mem[a4[31:6]] = {mk_tag(0, 1, 32'h4), pat_3c};
    repeat (3) step();
    rst_n = 1;
    step();

    c0 = resp_cnt;
    txn(1, a1, pat_a5, 0, 0, ID, 0, 0);
    chk("wr_cnt", resp_cnt - c0, 1);
    chk("wr_resp", {l_hit, l_dirty, l_err, l_rdata}, '0);

    txn(0, a1, '0, 0, 0, ID, 0, 0);
    chk("rd_hit_flags", {l_hit, l_dirty, l_err}, 3'b100);
    chk("rd_hit_data", l_rdata, pat_a5);

    txn(0, a2, '0, 0, 0, ID, 0, 0);
    chk("miss_flags", {l_hit, l_dirty, l_err}, 3'b000);
    chk("miss_data", l_rdata, pat_a5);

    txn(0, a3, '0, 0, 0, ID, 0, 0);
    chk("dirty_flags", {l_hit, l_dirty, l_err}, 3'b110);
    chk("dirty_data", l_rdata, pat_5a);

    txn(0, a4, '0, 0, 0, ID, 0, 0);
    chk("inval_flags", {l_hit, l_dirty, l_err}, 3'b010);

    c0 = resp_cnt;
    txn(0, a1, '0, 5, 3, ID, 1, 0);
    chk("bp_cnt", resp_cnt - c0, 1);
    chk("bp_flags", {l_hit, l_dirty, l_err}, 3'b100);

    c0 = resp_cnt;
    txn(0, a1, '0, 0, 0, 16'd2, 0, 0);
    chk("rid_err_cnt", resp_cnt - c0, 1);
    chk("rid_err", {l_hit, l_err}, 2'b11);

    txn(1, a2, pat_3c, 0, 1, 16'd3, 1, 0);
    chk("bid_err", {l_hit, l_dirty, l_err}, 3'b001);

    c0 = resp_cnt;
    txn(1, a3, pat_a5, 0, 0, ID, 0, 1);
    repeat (6) step();
    chk("rst_no_resp", resp_cnt - c0, 0);

    txn(0, a3, '0, 0, 0, ID, 0, 0);
    chk("post_rst_rd", {l_hit, l_dirty, l_rdata}, {2'b11, pat_5a});

    txn(0, a2, '0, 1, 0, ID, 0, 0);
    chk("wr2_rd", {l_hit, l_rdata}, {1'b1, pat_3c});

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_cache_axi_master.md
DRAM_CACHE_AXI_MASTER -- requirements
Module: dram_cache_axi_master

Interface
REQ-001 SHALL have parameter AXI_ID, default 1, ID driven on arid_o/awid_o/wid_o and expected on rid_i/bid_i.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (synchronous, active-low).
REQ-003 SHALL have these request ports: req_valid_i in 1; req_ready_o out 1; req_write_i in 1 (1 = fill/write, 0 = lookup/read); req_addr_i in 64; req_wdata_i in 512.
REQ-004 SHALL have these response ports: resp_valid_o out 1; resp_ready_i in 1; resp_hit_o out 1; resp_dirty_o out 1; resp_err_o out 1; resp_rdata_o out 512.
REQ-005 SHALL have these AR/R ports: arid_o out 16; araddr_o out 64; arvalid_o out 1; arready_i in 1; rid_i in 16; rdata_i in 576 (tag[575:512] plus data[511:0]); rvalid_i in 1; rready_o out 1.
REQ-006 SHALL have these AW/W/B ports: awid_o out 16; awaddr_o out 64; awvalid_o out 1; awready_i in 1; wid_o out 16; wdata_o out 512; wvalid_o out 1; wready_i in 1; bid_i in 16; bvalid_i in 1; bready_o out 1.

Function
REQ-007 SHALL use the FSM states IDLE, AR, R, AW, W, B and RESP; only one transaction is outstanding at a time.
REQ-008 SHALL assert req_ready_o only in IDLE; on req_valid_i & req_ready_o, SHALL capture addr/wdata/write and go to AW if write, else AR.
REQ-009 AR: arvalid_o=1, araddr_o=captured addr; hold stable until arready_i; then go to R.
REQ-010 R: rready_o=1; on rvalid_i SHALL capture rdata_i and rid_i, then go to RESP.
REQ-011 AW: awvalid_o=1, awaddr_o=captured addr, held until awready_i; then go to W. wvalid_o SHALL NOT be asserted before the AW handshake.
REQ-012 W: wvalid_o=1, wdata_o=captured wdata, held until wready_i; then go to B.
REQ-013 B: bready_o=1; on bvalid_i SHALL capture bid_i, then go to RESP.
REQ-014 Read hit SHALL be tag[63] (valid) AND tag[61:30]==addr[63:32]; resp_dirty_o SHALL be tag[62]; resp_rdata_o SHALL be the data[511:0] field.
REQ-015 Write response SHALL give resp_hit_o=0, resp_dirty_o=0 and resp_rdata_o=0.
REQ-016 resp_err_o SHALL be 1 when the captured rid/bid differs from AXI_ID; the response is still delivered.
REQ-017 RESP: resp_valid_o=1 with all resp fields stable; on resp_ready_i SHALL go to IDLE. If resp_ready_i is low, SHALL hold indefinitely.
REQ-018 The IDs on arid_o/awid_o/wid_o SHALL be constant AXI_ID; address/data outputs SHALL be registered (no combinational path from req_* to AXI outputs).
REQ-019 Latency SHALL be: request accept, then arvalid_o on the next cycle; resp_valid_o on the cycle after the R or B handshake.
REQ-020 A request presented while busy SHALL NOT be accepted and SHALL NOT corrupt captured state.

Reset
REQ-021 While rst_n=0 at a clk edge, SHALL enter IDLE; all valid/ready outputs SHALL be 0 except req_ready_o=1; resp fields SHALL be 0; captured registers SHALL be cleared.
REQ-022 A reset mid-transaction SHALL abandon the transaction (no response) and deassert all AXI valids from the next cycle.

Structure
REQ-023 The shared package dram_cache_pkg SHALL hold ADDR_W=64, DATA_W=512, ID_W=16, TAG_S=64, INDEX_W=26, OFFSET_W=6, BLANK_W=30, the tag bit positions (VALID=63, DIRTY=62, TAG field 61:30) and the FSM state enum.
REQ-024 The tag check SHALL be the combinational sub-module dram_cache_tag_cmp (tag, addr -> hit, dirty).

Verification
REQ-025 Write then read hit: write addr 0x0000_0001_0000_0040 with data pattern 0xA5 repeated, against the existing AXI slave model, then read the same addr -> resp_hit_o=1, resp_dirty_o=0, resp_rdata_o=0xA5 repeated, resp_err_o=0.
REQ-026 Read miss on tag: after REQ-025, read addr 0x0000_0002_0000_0040 (same index, different tag) -> resp_hit_o=0, resp_rdata_o = the stored line.
REQ-027 Backpressure: arready_i delayed 5 cycles and resp_ready_i low 3 cycles -> araddr_o stable throughout, one response, req_ready_o=0 until RESP completes.
REQ-028 ID error: slave returns rid_i=2 -> resp_err_o=1, with the response still delivered once.
REQ-029 Reset in W state: rst_n low 1 cycle -> no response; wvalid_o=0 next cycle; req_ready_o=1 after reset.
